// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmit framer states, bit-counter width.
package uart_pkg;

  // Wide enough for bit indices 0..8 (DWIDTH up to 9) and the stop-bit count.
  localparam int unsigned BIT_CNT_W = 4;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_ODD  = 2'b01,
    PAR_EVEN = 2'b10,
    PAR_MARK = 2'b11
  } par_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_parity.sv
// Combinational parity-bit generator with a run-time selectable mode.
module uart_tx_parity
  import uart_pkg::*;
#(
  parameter int unsigned DWIDTH = 8
) (
  input  logic [DWIDTH-1:0] data_i,
  input  logic [1:0]        par_mode_i,
  output logic              par_bit_o
);

  // Odd makes the total count of ones odd, even makes it even, mark is constant 1.
  always_comb begin
    par_bit_o = 1'b0;
    case (par_mode_e'(par_mode_i))
      PAR_NONE: par_bit_o = 1'b0;
      PAR_ODD:  par_bit_o = ~^data_i;
      PAR_EVEN: par_bit_o = ^data_i;
      PAR_MARK: par_bit_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined; otherwise
// par_mode is ignored and every frame goes DATA -> STOP.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [1:0]        par_mode,
  input  logic              stop2,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              txd,
  output logic              busy,
  output logic              tx_done
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DWIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DWIDTH-1:0]     shift_q, shift_d;
  logic                  stop2_q, stop2_d;
  logic                  txd_q, txd_d;
  logic                  busy_q, busy_d;
  logic                  in_ready_q, in_ready_d;
  logic                  tx_done_q, tx_done_d;
  logic                  bit_end_c;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_bit_q, par_bit_d;
  logic par_bit_c;

  // Parity is computed from the word at acceptance and held for the frame.
  uart_tx_parity #(.DWIDTH(DWIDTH)) u_parity (
    .data_i     (in_data),
    .par_mode_i (par_mode),
    .par_bit_o  (par_bit_c)
  );
`else
  logic unused_par_mode;
  assign unused_par_mode = ^par_mode;
`endif

  assign bit_end_c = (div_cnt_q == div_q);

  assign txd      = txd_q;
  assign busy     = busy_q;
  assign in_ready = in_ready_q;
  assign tx_done  = tx_done_q;

  // Next-state and next-output logic; outputs are computed for the next state.
  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    stop2_d    = stop2_q;
    txd_d      = txd_q;
    busy_d     = busy_q;
    in_ready_d = in_ready_q;
    tx_done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
`endif

    // Divider reloads on every bit boundary while a frame is in flight.
    if (state_q != ST_IDLE) begin
      div_cnt_d = bit_end_c ? '0 : div_cnt_q + DIV_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        txd_d      = 1'b1;
        busy_d     = 1'b0;
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          shift_d    = in_data;
          div_d      = baud_div;
          stop2_d    = stop2;
          div_cnt_d  = '0;
          bit_cnt_d  = '0;
`ifdef UART_TX_PARITY_EN
          par_en_d   = (par_mode_e'(par_mode) != PAR_NONE);
          par_bit_d  = par_bit_c;
`endif
          state_d    = ST_START;
          txd_d      = 1'b0;
          busy_d     = 1'b1;
          in_ready_d = 1'b0;
        end
      end

      ST_START: begin
        if (bit_end_c) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
          txd_d     = shift_q[0];
        end
      end

      ST_DATA: begin
        if (bit_end_c) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = ST_STOP;
            txd_d     = 1'b1;
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_d = ST_PARITY;
              txd_d   = par_bit_q;
            end
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            txd_d     = shift_q[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end_c) begin
          state_d   = ST_STOP;
          bit_cnt_d = '0;
          txd_d     = 1'b1;
        end
      end
`endif

      ST_STOP: begin
        if (bit_end_c) begin
          if (stop2_q && (bit_cnt_q == '0)) begin
            bit_cnt_d = BIT_CNT_W'(1);
          end else begin
            state_d    = ST_IDLE;
            bit_cnt_d  = '0;
            txd_d      = 1'b1;
            busy_d     = 1'b0;
            in_ready_d = 1'b1;
            tx_done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d    = ST_IDLE;
        txd_d      = 1'b1;
        busy_d     = 1'b0;
        in_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      div_cnt_q  <= '0;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      stop2_q    <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b1;
      tx_done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      stop2_q    <= stop2_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      in_ready_q <= in_ready_d;
      tx_done_q  <= tx_done_d;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
`endif
    end
  end

endmodule
